// File: rtl/pwm_capture_16bits.sv
// PWM input capture: measures the period and the active time of one external
// PWM signal in pwm_clk cycles. Results are published with a one-cycle
// cap_valid pulse and an optional interrupt pulse in the same cycle.
module pwm_capture_16bits #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_WIDTH  = 4
) (
    input  logic                  pwm_clk,
    input  logic                  reset,
    input  logic                  cap_onoff,
    input  logic                  int_onoff,
    input  logic                  polarity,
    input  logic [FILT_WIDTH-1:0] filt_len,
    input  logic                  pwm_in,
    output logic [CNT_WIDTH-1:0]  period_o,
    output logic [CNT_WIDTH-1:0]  hightime_o,
    output logic                  cap_valid,
    output logic                  cap_ovf,
    output logic                  interrupt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_in;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q, filt_dly_d;
    logic [FILT_WIDTH-1:0]  mcnt_q, mcnt_d;
    logic                   rise, fall;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hi_lat_q, hi_lat_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [CNT_WIDTH-1:0]   high_q, high_d;
    logic                   cap_valid_q, cap_valid_d;
    logic                   cap_ovf_q, cap_ovf_d;
    logic                   irq_q, irq_d;

    // Synchronizer shift and polarity-adjusted level seen by the filter.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_in   = sync_q[SYNC_STAGES-1] ^ polarity;
    end

    // Glitch filter: follow s_in only after filt_len+1 consecutive mismatches.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        filt_d     = filt_q;
        mcnt_d     = '0;
        filt_dly_d = filt_q;
        if (s_in != filt_q) begin
            // >= keeps a shortened filt_len from leaving the counter stranded above it.
            if (mcnt_q >= filt_len) filt_d = s_in;
            else                    mcnt_d = mcnt_q + FILT_WIDTH'(1);
        end
    end

    assign rise = filt_q & ~filt_dly_q;
    assign fall = ~filt_q & filt_dly_q;

    // Capture FSM: arm on the first rise, publish on every following rise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_lat_d    = hi_lat_q;
        period_d    = period_q;
        high_d      = high_q;
        cap_valid_d = 1'b0;
        cap_ovf_d   = cap_ovf_q;
        if (!cap_onoff) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (fall) hi_lat_d = cnt_q;
                    if (rise) begin
                        // A rise coinciding with cnt == max still captures.
                        period_d    = cnt_q;
                        high_d      = hi_lat_q;
                        cap_valid_d = 1'b1;
                        cap_ovf_d   = 1'b0;
                        cnt_d       = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        cap_ovf_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        irq_d = cap_valid_d & int_onoff;
    end

    // State register with synchronous reset.
    always_ff @(posedge pwm_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            sync_q      <= '0;
            filt_q      <= 1'b0;
            filt_dly_q  <= 1'b0;
            mcnt_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_lat_q    <= '0;
            period_q    <= '0;
            high_q      <= '0;
            cap_valid_q <= 1'b0;
            cap_ovf_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            filt_dly_q  <= filt_dly_d;
            mcnt_q      <= mcnt_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_lat_q    <= hi_lat_d;
            period_q    <= period_d;
            high_q      <= high_d;
            cap_valid_q <= cap_valid_d;
            cap_ovf_q   <= cap_ovf_d;
            irq_q       <= irq_d;
        end
    end

    assign period_o   = period_q;
    assign hightime_o = high_q;
    assign cap_valid  = cap_valid_q;
    assign cap_ovf    = cap_ovf_q;
    assign interrupt  = irq_q;

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Bench for pwm_capture_16bits: an edge-time model of the capture rules is
// compared against the DUT on every cycle, and directed scenarios pin the
// model with hand-computed literal results.
module tb_pwm_capture_16bits;

    localparam int CW   = 16;
    localparam int SS   = 2;
    localparam int FW   = 4;
    localparam int CMAX = 65535;

    logic          pwm_clk   = 1'b0;
    logic          reset     = 1'b1;
    logic          cap_onoff = 1'b0;
    logic          int_onoff = 1'b0;
    logic          polarity  = 1'b0;
    logic [FW-1:0] filt_len  = '0;
    logic          pwm_in    = 1'b0;
    logic [CW-1:0] period_o, hightime_o;
    logic          cap_valid, cap_ovf, interrupt;

    int n_tests = 0;
    int n_fail  = 0;
    int cap_cnt = 0;
    int int_cnt = 0;
    int base_c, base_i;

    pwm_capture_16bits #(.CNT_WIDTH(CW), .SYNC_STAGES(SS), .FILT_WIDTH(FW)) dut (
        .pwm_clk    (pwm_clk),
        .reset      (reset),
        .cap_onoff  (cap_onoff),
        .int_onoff  (int_onoff),
        .polarity   (polarity),
        .filt_len   (filt_len),
        .pwm_in     (pwm_in),
        .period_o   (period_o),
        .hightime_o (hightime_o),
        .cap_valid  (cap_valid),
        .cap_ovf    (cap_ovf),
        .interrupt  (interrupt)
    );

    initial forever #5 pwm_clk = ~pwm_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pwm_clk);
    endtask

    task automatic drive_pwm(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            pwm_in = 1'b1;
            wait_cyc(hi);
            pwm_in = 1'b0;
            wait_cyc(per - hi);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: edge times counted in clock edges since start. The filtered
    // level flips when the last filt_len+1 observed samples all disagree
    // with it; period/active time are differences of edge times.
    // ------------------------------------------------------------------
    logic          pin_hist[$];
    logic          s_win[$];
    logic          filt_m = 1'b0, filt_dly_m = 1'b0;
    logic          s_raw, s_now, rise_m, fall_m, flip;
    int            mode_m = 0;   // 0 disabled, 1 waiting for first rise, 2 measuring
    longint        edge_n = 0, t_rise = 0;
    int            hi_m = 0, span;
    logic [CW-1:0] exp_period = '0, exp_high = '0;
    logic          exp_valid = 1'b0, exp_ovf = 1'b0, exp_int = 1'b0;
    bit            model_live = 1'b0;

    initial forever begin
        @(posedge pwm_clk);
        edge_n++;
        if (reset) begin
            pin_hist.delete();
            s_win.delete();
            filt_m = 1'b0; filt_dly_m = 1'b0;
            mode_m = 0; hi_m = 0;
            exp_period = '0; exp_high = '0;
            exp_valid = 1'b0; exp_ovf = 1'b0; exp_int = 1'b0;
            model_live = 1'b1;
        end else begin
            s_raw = (pin_hist.size() >= SS) ? pin_hist[pin_hist.size() - SS] : 1'b0;
            pin_hist.push_back(pwm_in);
            if (pin_hist.size() > 8) void'(pin_hist.pop_front());
            s_now = s_raw ^ polarity;
            s_win.push_back(s_now);
            if (s_win.size() > 16) void'(s_win.pop_front());
            span = int'(filt_len) + 1;
            flip = (s_win.size() >= span);
            for (int i = 0; i < span; i++)
                if (flip && s_win[s_win.size() - 1 - i] == filt_m) flip = 1'b0;
            rise_m = filt_m & ~filt_dly_m;
            fall_m = ~filt_m & filt_dly_m;
            filt_dly_m = filt_m;
            if (flip) filt_m = ~filt_m;

            exp_valid = 1'b0;
            exp_int   = 1'b0;
            if (!cap_onoff) mode_m = 0;
            else if (mode_m == 0) mode_m = 1;
            else if (mode_m == 1) begin
                if (rise_m) begin mode_m = 2; t_rise = edge_n; end
            end else begin
                if (fall_m) hi_m = int'(edge_n - t_rise);
                if (rise_m) begin
                    exp_period = CW'(edge_n - t_rise);
                    exp_high   = CW'(hi_m);
                    exp_valid  = 1'b1;
                    exp_int    = int_onoff;
                    exp_ovf    = 1'b0;
                    t_rise     = edge_n;
                end else if (edge_n - t_rise == longint'(CMAX)) begin
                    exp_ovf = 1'b1;
                    mode_m  = 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge pwm_clk);
        if (model_live) begin
            check("period_o",   period_o,   exp_period);
            check("hightime_o", hightime_o, exp_high);
            check("cap_valid",  cap_valid,  exp_valid);
            check("cap_ovf",    cap_ovf,    exp_ovf);
            check("interrupt",  interrupt,  exp_int);
        end
    end

    // Pulse counters used by the directed checks.
    initial forever begin
        @(negedge pwm_clk);
        if (cap_valid === 1'b1) cap_cnt++;
        if (interrupt === 1'b1) int_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        wait_cyc(3); #1;
        check("rst_period", period_o, 0);
        check("rst_high",   hightime_o, 0);
        check("rst_valid",  cap_valid, 0);
        check("rst_ovf",    cap_ovf, 0);
        check("rst_irq",    interrupt, 0);
        reset = 1'b0; cap_onoff = 1'b1; int_onoff = 1'b1; filt_len = '0;
        wait_cyc(10);

        // Basic 2000/500: rises at 0, 2000, 4000 -> two captures
        base_c = cap_cnt; base_i = int_cnt;
        drive_pwm(2000, 500, 3);
        wait_cyc(10); #1;
        check("basic_caps",   cap_cnt - base_c, 2);
        check("basic_irqs",   int_cnt - base_i, 2);
        check("basic_period", period_o, 2000);
        check("basic_high",   hightime_o, 500);

        // Glitch filter, filt_len=3: 2-cycle pulse rejected, 4-cycle accepted.
        // The accepted rise is 2032 cycles after the last rise plus 3 extra
        // cycles of filter latency -> period 2035.
        filt_len = 4'd3; int_onoff = 1'b0;
        base_c = cap_cnt;
        pwm_in = 1'b1; wait_cyc(2); pwm_in = 1'b0; wait_cyc(20); #1;
        check("glitch_reject", cap_cnt - base_c, 0);
        pwm_in = 1'b1; wait_cyc(4); pwm_in = 1'b0; wait_cyc(20); #1;
        check("glitch_accept", cap_cnt - base_c, 1);
        check("glitch_period", period_o, 2035);
        check("glitch_high",   hightime_o, 500);

        // Overflow: re-arm, hold input high
        cap_onoff = 1'b0; filt_len = '0; wait_cyc(5);
        cap_onoff = 1'b1; wait_cyc(5);
        base_c = cap_cnt;
        pwm_in = 1'b1; wait_cyc(65545); #1;
        check("ovf_flag",   cap_ovf, 1);
        check("ovf_caps",   cap_cnt - base_c, 0);
        check("ovf_period", period_o, 2035);
        check("ovf_high",   hightime_o, 500);

        // Restart after overflow: capture at the 2nd rise clears cap_ovf
        pwm_in = 1'b0; wait_cyc(20);
        base_c = cap_cnt;
        drive_pwm(2000, 500, 2);
        wait_cyc(10); #1;
        check("restart_caps",   cap_cnt - base_c, 1);
        check("restart_ovf",    cap_ovf, 0);
        check("restart_period", period_o, 2000);
        check("restart_high",   hightime_o, 500);

        // Polarity inverted: active time is the low phase
        cap_onoff = 1'b0; polarity = 1'b1; wait_cyc(20);
        cap_onoff = 1'b1; wait_cyc(10);
        base_c = cap_cnt; base_i = int_cnt;
        drive_pwm(2000, 500, 2);
        wait_cyc(10); #1;
        check("pol_caps",   cap_cnt - base_c, 1);
        check("pol_irqs",   int_cnt - base_i, 0);
        check("pol_period", period_o, 2000);
        check("pol_high",   hightime_o, 1500);

        // Disable mid-period: no captures, outputs hold
        cap_onoff = 1'b0; polarity = 1'b0; wait_cyc(20);
        cap_onoff = 1'b1; wait_cyc(10);
        drive_pwm(300, 100, 3);
        pwm_in = 1'b1; wait_cyc(100); pwm_in = 1'b0; wait_cyc(50);
        cap_onoff = 1'b0;
        base_c = cap_cnt;
        wait_cyc(150);
        drive_pwm(300, 100, 2);
        wait_cyc(10); #1;
        check("dis_caps",   cap_cnt - base_c, 0);
        check("dis_period", period_o, 300);
        check("dis_high",   hightime_o, 100);

        // Re-enable: nothing after one rise, capture at the second
        cap_onoff = 1'b1; wait_cyc(10);
        base_c = cap_cnt;
        drive_pwm(400, 150, 1); #1;
        check("reen_first_rise", cap_cnt - base_c, 0);
        drive_pwm(400, 150, 1);
        wait_cyc(10); #1;
        check("reen_caps",   cap_cnt - base_c, 1);
        check("reen_period", period_o, 400);
        check("reen_high",   hightime_o, 150);

        // Reset mid-measurement
        pwm_in = 1'b1; wait_cyc(50);
        reset = 1'b1; pwm_in = 1'b0;
        wait_cyc(1);
        reset = 1'b0; #1;
        check("mrst_period", period_o, 0);
        check("mrst_high",   hightime_o, 0);
        check("mrst_valid",  cap_valid, 0);
        check("mrst_ovf",    cap_ovf, 0);
        wait_cyc(10);
        base_c = cap_cnt;
        drive_pwm(400, 150, 2);
        wait_cyc(10); #1;
        check("mrst_caps",    cap_cnt - base_c, 1);
        check("mrst_period2", period_o, 400);
        check("mrst_high2",   hightime_o, 150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
